// File: rtl/nvram_upload.sv
// HPS upload responder: streams the EAROM shadow RAM back to the HPS byte by byte
// and tracks whether game writes have happened since the last complete upload.
module nvram_upload #(
    parameter int unsigned ADDR_W = 6,
    parameter logic [7:0]  INDEX  = 8'd4,
    parameter logic [7:0]  FILL   = 8'h00
) (
    input  logic              clk_12,
    input  logic              RESET_L,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_busy,
    input  logic [7:0]        ram_dout,
    input  logic              game_wr,
    output logic              nvram_dirty
);

    localparam int unsigned      DEPTH = 1 << ADDR_W;
    localparam int unsigned      CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        din_q, din_d;
    logic              wait_q, wait_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  served_q, served_d;
    logic              wflag_q, wflag_d;
    logic              dirty_q, dirty_d;
    logic              session_q, session_d;
    logic              upload_q;

    logic sel_c, accept_c, in_range_c, upload_rise_c, upload_fall_c, req_done_c;

    assign sel_c         = ioctl_upload && (ioctl_index == INDEX);
    assign accept_c      = ioctl_rd && sel_c && (state_q == ST_IDLE);
    assign in_range_c    = (ioctl_addr[24:ADDR_W] == '0);
    assign upload_rise_c = sel_c && !upload_q;
    assign upload_fall_c = !ioctl_upload && upload_q;
    assign req_done_c    = rd_q && !ram_busy;

    // State register
    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a dropped upload abandons any in-flight read
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c && in_range_c) state_d = ST_REQ;
            ST_REQ: begin
                if (!ioctl_upload)   state_d = ST_IDLE;
                else if (req_done_c) state_d = ST_DATA;
            end
            ST_DATA: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and bookkeeping next values
    always_comb begin
        din_d     = din_q;
        wait_d    = wait_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        served_d  = served_q;
        wflag_d   = wflag_q;
        dirty_d   = dirty_q;
        session_d = session_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (in_range_c) begin
                        wait_d = 1'b1;
                        rd_d   = 1'b1;
                        addr_d = ioctl_addr[ADDR_W-1:0];
                    end else begin
                        din_d = FILL;
                    end
                end
            end
            ST_REQ: begin
                if (!ioctl_upload || req_done_c) rd_d = 1'b0;
                if (!ioctl_upload)               wait_d = 1'b0;
            end
            ST_DATA: begin
                rd_d   = 1'b0;
                wait_d = 1'b0;
                if (ioctl_upload) begin
                    din_d = ram_dout;
                    if (served_q != FULL) served_d = served_q + CNT_W'(1);
                end
            end
            default: begin
                rd_d   = 1'b0;
                wait_d = 1'b0;
            end
        endcase

        if (upload_rise_c) begin
            session_d = 1'b1;
            served_d  = '0;
            wflag_d   = 1'b0;
        end else if (upload_fall_c) begin
            session_d = 1'b0;
        end
        if (game_wr && (session_q || upload_rise_c)) wflag_d = 1'b1;

        // A write coincident with the clearing edge keeps the flag set
        if (upload_fall_c && session_q && (served_q == FULL) && !wflag_q) dirty_d = 1'b0;
        if (game_wr) dirty_d = 1'b1;
    end

    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            din_q     <= 8'h00;
            wait_q    <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            served_q  <= '0;
            wflag_q   <= 1'b0;
            dirty_q   <= 1'b0;
            session_q <= 1'b0;
            upload_q  <= 1'b0;
        end else begin
            din_q     <= din_d;
            wait_q    <= wait_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            served_q  <= served_d;
            wflag_q   <= wflag_d;
            dirty_q   <= dirty_d;
            session_q <= session_d;
            upload_q  <= ioctl_upload;
        end
    end

    assign ioctl_din   = din_q;
    assign ioctl_wait  = wait_q;
    assign ram_rd      = rd_q;
    assign ram_addr    = addr_q;
    assign nvram_dirty = dirty_q;

endmodule
